fl: RTL

Free list for the 2-wide R10K-style rename stage. It sits directly upstream of the map table and supplies the two next free physical register tags (`fl_pr0`, `fl_pr1`) that the map table writes for newly dispatched destinations. It reclaims T_old tags from the ROB at retirement. On a retirement-time mispredict it restores every speculatively allocated tag in one cycle.

---
 rtl/fl.sv | 92 +++++++++
 1 files changed

// File: rtl/fl.sv
// fl: free list for the 2-wide rename stage.
//   Circular buffer of free physical register tags. Supplies the next two free
//   tags at head, reclaims T_old tags from retirement at tail, and restores all
//   speculatively allocated tags on a retirement-time mispredict by snapping
//   head back to the retirement head.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   rob_dispatch_num      - tags consumed this cycle (clamped to fl_avail_num)
//   rob_retire_num        - retiring instructions this cycle (0..2)
//   rob_retire_pr0/1      - T_old tags freed by older/younger retiring instr
//   rob_recover           - squash all in-flight allocations
//   fl_pr0/fl_pr1         - tags at head and head+1
//   fl_avail_num          - min(fl_count, 2)
//   fl_count              - number of free tags
module fl #(
  parameter int PR_NUM  = 64,
  parameter int AR_NUM  = 32,
  parameter int FL_SIZE = PR_NUM - AR_NUM
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 rob_dispatch_num,
  input  logic [1:0]                 rob_retire_num,
  input  logic [6:0]                 rob_retire_pr0,
  input  logic [6:0]                 rob_retire_pr1,
  input  logic                       rob_recover,
  output logic [6:0]                 fl_pr0,
  output logic [6:0]                 fl_pr1,
  output logic [1:0]                 fl_avail_num,
  output logic [$clog2(FL_SIZE):0]   fl_count
);

  localparam int IW = $clog2(FL_SIZE);
  localparam int PW = IW + 1;
  localparam int TW = 7;

  logic [TW-1:0] entries_q [FL_SIZE];
  logic [TW-1:0] entries_d [FL_SIZE];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] rhead_q, rhead_d;

  logic [IW-1:0] head_idx, head1_idx;
  logic [IW-1:0] tail_idx, tail1_idx;
  logic [1:0]    disp_eff;

  always_comb begin
    head_idx     = head_q[IW-1:0];
    head1_idx    = head_q[IW-1:0] + IW'(1);
    fl_pr0       = entries_q[head_idx];
    fl_pr1       = entries_q[head1_idx];
    fl_count     = tail_q - head_q;
    fl_avail_num = (fl_count >= PW'(2)) ? 2'd2 : fl_count[1:0];
  end

  always_comb begin
    entries_d = entries_q;
    tail_idx  = tail_q[IW-1:0];
    tail1_idx = tail_q[IW-1:0] + IW'(1);

    if (rob_retire_num != 2'd0) entries_d[tail_idx]  = rob_retire_pr0;
    if (rob_retire_num == 2'd2) entries_d[tail1_idx] = rob_retire_pr1;

    tail_d  = tail_q  + PW'(rob_retire_num);
    rhead_d = rhead_q + PW'(rob_retire_num);

    // Over-requests are clamped so head can never pass tail.
    disp_eff = (rob_dispatch_num > fl_avail_num) ? fl_avail_num : rob_dispatch_num;

    // Recovery restores head to the post-retire rhead; squashed tags between
    // rhead and the old head are still intact in the buffer.
    if (rob_recover) head_d = rhead_d;
    else             head_d = head_q + PW'(disp_eff);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        entries_q[i] <= TW'(AR_NUM + i);
      end
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PW'(FL_SIZE);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      rhead_q   <= rhead_d;
      tail_q    <= tail_d;
    end
  end

endmodule
